cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/opclass_decode.sv | 30 +++
 rtl/cpu_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU sequencer: opcodes, state
// encoding, mux select encodings and the one-hot opcode class layout.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_CUST   = 7'b0001011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_JALR  = 2'd2;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;

  // Bit positions inside the one-hot class vector
  localparam int CLS_R      = 0;
  localparam int CLS_CUST   = 1;
  localparam int CLS_IALU   = 2;
  localparam int CLS_LUI    = 3;
  localparam int CLS_AUIPC  = 4;
  localparam int CLS_JALR   = 5;
  localparam int CLS_LOAD   = 6;
  localparam int CLS_BRANCH = 7;
  localparam int CLS_STORE  = 8;
  localparam int CLS_JAL    = 9;
  localparam int NUM_CLS    = 10;

  typedef logic [NUM_CLS-1:0] opclass_t;

  typedef struct packed {
    logic       imm_control;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/opclass_decode.sv
// Maps a 7-bit opcode onto a one-hot instruction class; unknown opcodes
// produce an all-zero class vector with illegal set.
module opclass_decode
  import cpu_pkg::*;
(
  input  logic [6:0] op,
  output opclass_t   op_class,
  output logic       illegal
);

  // Pure lookup from opcode to class bit
  always_comb begin
    op_class = '0;
    illegal  = 1'b0;
    case (op)
      OP_R:      op_class[CLS_R]      = 1'b1;
      OP_CUST:   op_class[CLS_CUST]   = 1'b1;
      OP_IALU:   op_class[CLS_IALU]   = 1'b1;
      OP_LUI:    op_class[CLS_LUI]    = 1'b1;
      OP_AUIPC:  op_class[CLS_AUIPC]  = 1'b1;
      OP_JALR:   op_class[CLS_JALR]   = 1'b1;
      OP_LOAD:   op_class[CLS_LOAD]   = 1'b1;
      OP_BRANCH: op_class[CLS_BRANCH] = 1'b1;
      OP_STORE:  op_class[CLS_STORE]  = 1'b1;
      OP_JAL:    op_class[CLS_JAL]    = 1'b1;
      default:   illegal              = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer. Fetches an instruction, latches its
// opcode, and steps through decode/execute/memory/writeback issuing
// combinational control strobes.
//
// state  | meaning
// FETCH  | memRead until memReady, latch opcode, pulse irWrite
// DECODE | immediate decoder on, route illegal opcodes to TRAP
// EXEC   | ALU operand select, branch/jump pc update
// MEM    | load or store until memReady
// WB     | register write, sequential pc update for non-jumps
// TRAP   | illegal held, only reset leaves
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        memReady,
  input  logic        branchTaken,
  output logic        immControl,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        aluSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic [1:0]  memToReg,
  output logic        illegal,
  output logic [2:0]  state
);

  logic [2:0] state_q, state_d;
  logic [6:0] op_q, op_d;
  opclass_t   cls;
  logic       op_illegal;
  ctrl_t      ctrl;
  logic       is_jump;

  // Only the opcode field matters to sequencing
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[31:7];

  opclass_decode u_opclass_decode (
    .op       (op_q),
    .op_class (cls),
    .illegal  (op_illegal)
  );

  assign is_jump = cls[CLS_JAL] | cls[CLS_JALR];

  // Next-state and control strobes; reset overrides everything so that
  // strobes drop in the same cycle reset is seen
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (memReady) begin
          ctrl.ir_write = 1'b1;
          op_d          = instr[6:0];
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.imm_control = 1'b1;
        state_d          = op_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        ctrl.imm_control = 1'b1;
        ctrl.alu_src     = ~(cls[CLS_R] | cls[CLS_CUST] | cls[CLS_BRANCH]);
        if (cls[CLS_BRANCH]) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = branchTaken ? PC_SRC_IMM : PC_SRC_PLUS4;
          state_d       = ST_FETCH;
        end else if (cls[CLS_JAL]) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_IMM;
          state_d       = ST_WB;
        end else if (cls[CLS_JALR]) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_JALR;
          state_d       = ST_WB;
        end else if (cls[CLS_LOAD] | cls[CLS_STORE]) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (cls[CLS_LOAD]) begin
          ctrl.mem_read = 1'b1;
          if (memReady) state_d = ST_WB;
        end else if (cls[CLS_STORE]) begin
          ctrl.mem_write = 1'b1;
          if (memReady) begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_PLUS4;
            state_d       = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        if (cls[CLS_LOAD]) ctrl.mem_to_reg = WB_SRC_MEM;
        else if (is_jump)  ctrl.mem_to_reg = WB_SRC_PC4;
        else               ctrl.mem_to_reg = WB_SRC_ALU;
        if (!is_jump) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_PLUS4;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (reset) begin
      state_d = ST_FETCH;
      op_d    = '0;
      ctrl    = '0;
    end
  end

  // State and opcode registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    op_q    <= op_d;
  end

  assign immControl = ctrl.imm_control;
  assign irWrite    = ctrl.ir_write;
  assign pcWrite    = ctrl.pc_write;
  assign pcSrc      = ctrl.pc_src;
  assign aluSrc     = ctrl.alu_src;
  assign memRead    = ctrl.mem_read;
  assign memWrite   = ctrl.mem_write;
  assign regWrite   = ctrl.reg_write;
  assign memToReg   = ctrl.mem_to_reg;
  assign illegal    = ctrl.illegal;
  assign state      = state_q;

endmodule
